// File: rtl/eth_pkg.sv
// Shared constants and state encoding for the Ethernet transmit framer.
// CRC constants follow the reflected IEEE 802.3 CRC-32.
package eth_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    // ST_ABORT is the single tx_er cycle emitted after an underrun.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_PAYLOAD,
        ST_PAD,
        ST_FCS,
        ST_IFG,
        ST_ABORT
    } state_t;

    // FCS byte idx (0 = first on the wire) of the complemented CRC.
    function automatic logic [7:0] fcs_byte(
        input logic [31:0] crc,
        input logic [1:0]  idx
    );
        logic [31:0] fcs;
        fcs = ~crc;
        unique case (idx)
            2'd0: return fcs[7:0];
            2'd1: return fcs[15:8];
            2'd2: return fcs[23:16];
            default: return fcs[31:24];
        endcase
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational byte-wide step of the reflected CRC-32.
// The caller owns the CRC register.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    // Shift eight data bits through the LFSR, LSB first.
    always_comb begin
        c = crc_in ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet TX framer: drains a payload FIFO into a GMII-style byte
// stream with preamble, SFD, zero pad, CRC-32 FCS and inter-frame gap.
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter int unsigned MIN_LEN = 60,
    parameter int unsigned MAX_LEN = 1514,
    parameter int unsigned PRE_LEN = 7,
    parameter int unsigned IFG_LEN = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [10:0] frame_len,
    output logic        busy,
    output logic        len_err,
    output logic        underrun,
    output logic        fifo_rd,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    output logic        tx_en,
    output logic        tx_er,
    output logic [7:0]  tx_data
);

    localparam logic [10:0] MIN_L = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L = 11'(MAX_LEN);
    localparam logic [10:0] PRE_L = 11'(PRE_LEN);
    localparam logic [10:0] IFG_L = 11'(IFG_LEN);

    state_t      state;
    state_t      state_nx;
    logic [10:0] cnt;
    logic [10:0] len_q;
    logic [31:0] crc_q;
    logic [31:0] crc_nx;
    logic        len_ok;
    logic        accept;
    logic        last_pay;
    logic        rd_due;

    assign len_ok   = (frame_len != 11'd0) && (frame_len <= MAX_L);
    assign accept   = (state == ST_IDLE) && start && len_ok;
    assign last_pay = (cnt == len_q - 11'd1);

    // A read is due one cycle ahead of every payload byte.
    assign rd_due = (state == ST_SFD)
                 || ((state == ST_PAYLOAD) && !last_pay);

    crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data    (tx_data),
        .crc_out (crc_nx)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) state_nx = ST_PREAMBLE;
            end
            ST_PREAMBLE: begin
                if (cnt == PRE_L - 11'd1) state_nx = ST_SFD;
            end
            ST_SFD: begin
                if (fifo_empty) state_nx = ST_ABORT;
                else            state_nx = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                if (rd_due && fifo_empty) begin
                    state_nx = ST_ABORT;
                end else if (last_pay) begin
                    if (len_q < MIN_L) state_nx = ST_PAD;
                    else               state_nx = ST_FCS;
                end
            end
            ST_PAD: begin
                if (cnt == MIN_L - 11'd1) state_nx = ST_FCS;
            end
            ST_FCS: begin
                if (cnt == 11'd3) state_nx = ST_IFG;
            end
            ST_IFG: begin
                if (cnt == IFG_L - 11'd1) state_nx = ST_IDLE;
            end
            ST_ABORT: begin
                state_nx = ST_IFG;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Output decode; payload bytes pass straight through from the FIFO.
    always_comb begin
        busy     = (state != ST_IDLE);
        tx_en    = 1'b0;
        tx_er    = 1'b0;
        tx_data  = 8'h00;
        underrun = 1'b0;
        fifo_rd  = rd_due && !fifo_empty;
        unique case (state)
            ST_IDLE: begin
            end
            ST_PREAMBLE: begin
                tx_en   = 1'b1;
                tx_data = PREAMBLE_BYTE;
            end
            ST_SFD: begin
                tx_en   = 1'b1;
                tx_data = SFD_BYTE;
            end
            ST_PAYLOAD: begin
                tx_en   = 1'b1;
                tx_data = fifo_data;
            end
            ST_PAD: begin
                tx_en = 1'b1;
            end
            ST_FCS: begin
                tx_en   = 1'b1;
                tx_data = fcs_byte(crc_q, cnt[1:0]);
            end
            ST_IFG: begin
            end
            ST_ABORT: begin
                tx_en    = 1'b1;
                tx_er    = 1'b1;
                underrun = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Per-state cycle counter; PAD keeps counting from the payload so
    // that it ends once MIN_LEN bytes have gone out.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 11'd0;
        end else if (state_nx == ST_IDLE) begin
            cnt <= 11'd0;
        end else if ((state_nx != state) && (state_nx != ST_PAD)) begin
            cnt <= 11'd0;
        end else begin
            cnt <= cnt + 11'd1;
        end
    end

    // Latch the frame length on an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q <= 11'd0;
        end else if (accept) begin
            len_q <= frame_len;
        end
    end

    // One-cycle pulse for a start carrying an illegal length.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_err <= 1'b0;
        end else begin
            len_err <= (state == ST_IDLE) && start && !len_ok;
        end
    end

    // CRC register: seeded in SFD, advanced over payload and pad only.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= CRC_INIT;
        end else if (state == ST_SFD) begin
            crc_q <= CRC_INIT;
        end else if ((state == ST_PAYLOAD) || (state == ST_PAD)) begin
            crc_q <= crc_nx;
        end
    end

endmodule
